// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and memory-side line transfer signals of mem_arbiter.
// slave is the arbiter's view; master is the view of the surrounding caches/memory.
interface mem_arbiter_if #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) ();
  // I-side cache
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  // D-side cache
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  // Physical memory port
  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_address;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  logic              m_resp;

  modport slave (
    input  i_read, i_address,
    input  d_read, d_write, d_address, d_wdata,
    input  m_rdata, m_resp,
    output i_rdata, i_resp,
    output d_rdata, d_resp,
    output m_read, m_write, m_address, m_wdata
  );

  modport master (
    output i_read, i_address,
    output d_read, d_write, d_address, d_wdata,
    output m_rdata, m_resp,
    input  i_rdata, i_resp,
    input  d_rdata, d_resp,
    input  m_read, m_write, m_address, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between the I-side and D-side
// caches, one transaction at a time, with saturating contention counters.
// Optional feature macro ARB_RR_EN: round-robin conflict resolution; when
// undefined the D-side always wins a conflict.
module mem_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] cnt_i_grants,
  output logic [CNT_W-1:0] cnt_d_grants,
  output logic [CNT_W-1:0] cnt_conflicts
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } side_t;

  state_t            state_q, state_d;
  side_t             last_grant_q;
  logic              grant_i, grant_d, conflict, done;
  logic              i_req, d_req;

  logic              m_read_q, m_write_q;
  logic [ADDR_W-1:0] m_address_q;
  logic [LINE_W-1:0] m_wdata_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  // Memory request comes only from the grant latch, never from live requester inputs
  assign bus.m_read    = m_read_q;
  assign bus.m_write   = m_write_q;
  assign bus.m_address = m_address_q;
  assign bus.m_wdata   = m_wdata_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Arbitration, next state and same-cycle response routing
  always_comb begin
    state_d     = state_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    conflict    = 1'b0;
    done        = 1'b0;
    bus.i_resp  = 1'b0;
    bus.d_resp  = 1'b0;
    bus.i_rdata = '0;
    bus.d_rdata = '0;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          conflict = 1'b1;
`ifdef ARB_RR_EN
          if (last_grant_q == GNT_D) grant_i = 1'b1;
          else                       grant_d = 1'b1;
`else
          grant_d = 1'b1;
`endif
        end else if (i_req) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_i)      state_d = SERVE_I;
        else if (grant_d) state_d = SERVE_D;
      end
      SERVE_I: begin
        if (bus.m_resp) begin
          bus.i_resp  = 1'b1;
          bus.i_rdata = bus.m_rdata;
          done        = 1'b1;
          state_d     = IDLE;
        end
      end
      SERVE_D: begin
        if (bus.m_resp) begin
          bus.d_resp  = 1'b1;
          bus.d_rdata = bus.m_rdata;
          done        = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant latch: capture the winner's transaction, release the memory port on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GNT_I;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
      m_address_q  <= '0;
      m_wdata_q    <= '0;
    end else if (grant_i) begin
      last_grant_q <= GNT_I;
      m_read_q     <= 1'b1;
      m_write_q    <= 1'b0;
      m_address_q  <= bus.i_address;
      m_wdata_q    <= '0;
    end else if (grant_d) begin
      last_grant_q <= GNT_D;
      m_read_q     <= bus.d_read;
      m_write_q    <= bus.d_write;
      m_address_q  <= bus.d_address;
      m_wdata_q    <= bus.d_wdata;
    end else if (done) begin
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
    end
  end

  // Saturating contention counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_i_grants  <= '0;
      cnt_d_grants  <= '0;
      cnt_conflicts <= '0;
    end else begin
      if (grant_i)  cnt_i_grants  <= sat_inc(cnt_i_grants);
      if (grant_d)  cnt_d_grants  <= sat_inc(cnt_d_grants);
      if (conflict) cnt_conflicts <= sat_inc(cnt_conflicts);
    end
  end

  // Grant history tracks every grant in both arbitration modes
  a_last_i: assert property (@(posedge clk) disable iff (!rst_n) grant_i |=> (last_grant_q == GNT_I));
  a_last_d: assert property (@(posedge clk) disable iff (!rst_n) grant_d |=> (last_grant_q == GNT_D));
  // At most one owner completes per cycle
  a_one_resp: assert property (@(posedge clk) disable iff (!rst_n) !(bus.i_resp && bus.d_resp));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requesters and memory around mem_arbiter, checked
// cycle by cycle against a transaction-level owner/scoreboard model.
module tb_mem_arbiter;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;
  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;
  localparam logic [LINE_W-1:0] PAT_B  = {8{32'hB0B0_1234}};
  localparam logic [LINE_W-1:0] PAT_B2 = {8{32'hC3C3_5678}};

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } job_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cnt_i_grants, cnt_d_grants, cnt_conflicts;

  mem_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .cnt_i_grants  (cnt_i_grants),
    .cnt_d_grants  (cnt_d_grants),
    .cnt_conflicts (cnt_conflicts)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: who owns the memory port and what it asked for
  int                owner = OWN_NONE;
  int                last_side = OWN_I;
  logic              exp_wr;
  logic [ADDR_W-1:0] exp_addr;
  logic [LINE_W-1:0] exp_wdata;
  logic [31:0]       m_cnt_i = '0, m_cnt_d = '0, m_cnt_c = '0;
  logic [LINE_W-1:0] ref_mem [logic [ADDR_W-1:0]];

  // Memory environment
  logic [LINE_W-1:0] mem_st [logic [ADDR_W-1:0]];
  bit                mem_busy = 0, mem_stale = 0, mem_wr = 0;
  int                mem_cnt = 0, mem_lat = 0;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;

  // Requesters
  logic [ADDR_W-1:0] iq[$];
  job_t              dq[$];
  bit                i_act = 0, i_done = 0, d_act = 0, d_done = 0;
  bit                flip_en = 0, spur_en = 0;

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [LINE_W-1:0] line_default(input logic [ADDR_W-1:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [LINE_W-1:0] ref_get(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : line_default(a);
  endfunction

  function automatic logic [LINE_W-1:0] mem_get(input logic [ADDR_W-1:0] a);
    return mem_st.exists(a) ? mem_st[a] : line_default(a);
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < int'(LINE_W / 32); k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    return ADDR_W'($urandom_range(0, 15) * 32);
  endfunction

  function automatic job_t mk_job(input logic wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] w);
    job_t j;
    j.wr = wr; j.addr = a; j.wdata = w;
    return j;
  endfunction

  // Conflict policy applied when both sides ask while the port is free
  function automatic int pick(input bit pi, input bit pd);
    if (pi && pd) begin
`ifdef ARB_RR_EN
      return (last_side == OWN_I) ? OWN_D : OWN_I;
`else
      return OWN_D;
`endif
    end
    if (pi) return OWN_I;
    if (pd) return OWN_D;
    return OWN_NONE;
  endfunction

  // Advance the model across one clock edge using the inputs held in the last cycle
  task automatic model_edge();
    int  w;
    bit  pi, pd;
    pi = bus.i_read;
    pd = bus.d_read | bus.d_write;
    if (owner == OWN_NONE) begin
      if (pi && pd) m_cnt_c = sat(m_cnt_c);
      w = pick(pi, pd);
      if (w == OWN_I) begin
        owner = OWN_I; last_side = OWN_I; m_cnt_i = sat(m_cnt_i);
        exp_wr = 1'b0; exp_addr = bus.i_address;
      end else if (w == OWN_D) begin
        owner = OWN_D; last_side = OWN_D; m_cnt_d = sat(m_cnt_d);
        exp_wr = bus.d_write; exp_addr = bus.d_address; exp_wdata = bus.d_wdata;
      end
    end else if (bus.m_resp) begin
      owner = OWN_NONE;
    end
  endtask

  // Drive memory response and requester inputs for the new cycle
  task automatic drive();
    bus.m_resp  = 1'b0;
    bus.m_rdata = rand_line();
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        bus.m_resp = 1'b1;
        mem_busy   = 0;
        if (!mem_wr)         bus.m_rdata = mem_get(mem_addr);
        else if (!mem_stale) mem_st[mem_addr] = mem_wdata;
      end
    end else if (spur_en && rst_n && owner == OWN_NONE && $urandom_range(0, 9) == 0) begin
      bus.m_resp = 1'b1;
    end

    if (i_done) begin
      bus.i_read = 1'b0; bus.i_address = $urandom; i_done = 0;
    end else if (!i_act && iq.size() > 0) begin
      bus.i_read = 1'b1; bus.i_address = iq.pop_front(); i_act = 1;
    end

    if (d_done) begin
      bus.d_read = 1'b0; bus.d_write = 1'b0; d_done = 0;
    end else if (!d_act && dq.size() > 0) begin
      job_t j;
      j = dq.pop_front();
      bus.d_read = ~j.wr; bus.d_write = j.wr; bus.d_address = j.addr; bus.d_wdata = j.wdata;
      d_act = 1;
    end else if (d_act && owner == OWN_D && flip_en && $urandom_range(0, 2) == 0) begin
      bus.d_address = $urandom; bus.d_wdata = rand_line();
    end
  endtask

  // Compare every DUT output with the model, then let the environment react
  task automatic check();
    bit                er_i, er_d;
    logic [LINE_W-1:0] e;
    check_eq("m_read",  LINE_W'(bus.m_read),  LINE_W'(owner == OWN_I || (owner == OWN_D && !exp_wr)));
    check_eq("m_write", LINE_W'(bus.m_write), LINE_W'(owner == OWN_D && exp_wr));
    if (owner != OWN_NONE) check_eq("m_address", LINE_W'(bus.m_address), LINE_W'(exp_addr));
    if (owner == OWN_D && exp_wr) check_eq("m_wdata", bus.m_wdata, exp_wdata);
    er_i = (owner == OWN_I) && bus.m_resp;
    er_d = (owner == OWN_D) && bus.m_resp;
    check_eq("i_resp", LINE_W'(bus.i_resp), LINE_W'(er_i));
    check_eq("d_resp", LINE_W'(bus.d_resp), LINE_W'(er_d));
    e = er_i ? ref_get(exp_addr) : '0;
    check_eq("i_rdata", bus.i_rdata, e);
    e = er_d ? (exp_wr ? bus.m_rdata : ref_get(exp_addr)) : '0;
    check_eq("d_rdata", bus.d_rdata, e);
    check_eq("cnt_i_grants",  LINE_W'(cnt_i_grants),  LINE_W'(m_cnt_i));
    check_eq("cnt_d_grants",  LINE_W'(cnt_d_grants),  LINE_W'(m_cnt_d));
    check_eq("cnt_conflicts", LINE_W'(cnt_conflicts), LINE_W'(m_cnt_c));
    if (er_i) begin i_act = 0; i_done = 1; end
    if (er_d) begin
      d_act = 0; d_done = 1;
      if (exp_wr) ref_mem[exp_addr] = exp_wdata;
    end
    if ((bus.m_read || bus.m_write) && !mem_busy && !bus.m_resp) begin
      mem_busy  = 1; mem_stale = 0;
      mem_wr    = bus.m_write;
      mem_addr  = bus.m_address;
      mem_wdata = bus.m_wdata;
      mem_cnt   = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 6));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    drive();
    @(negedge clk);
    check();
  endtask

  function automatic bit all_quiet();
    return iq.size() == 0 && dq.size() == 0 && !i_act && !d_act && !i_done && !d_done
           && owner == OWN_NONE && !mem_busy;
  endfunction

  task automatic run_until_idle(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (!all_quiet() && n < max_cyc) begin
      step();
      n++;
    end
    check_eq(tag, LINE_W'(all_quiet()), LINE_W'(1'b1));
  endtask

  initial begin
    int n, sc;
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.m_resp = 1'b0; bus.m_rdata = '0;

    // Reset values
    repeat (3) step();
    check_eq("rst_cnt_i", LINE_W'(cnt_i_grants), '0);
    rst_n = 1'b1;

    // I-only read, fixed memory latency of 5
    mem_lat = 5;
    iq.push_back(32'h0000_0060);
    run_until_idle(40, "i_read_0x60_done");
    check_eq("cnt_i_after_read", LINE_W'(cnt_i_grants), LINE_W'(32'd1));

    // D write-back, then read it back through the I side
    dq.push_back(mk_job(1'b1, 32'h0000_1000, PAT_B));
    run_until_idle(40, "d_write_done");
    iq.push_back(32'h0000_1000);
    run_until_idle(40, "i_readback_done");

    // Simultaneous requests: one conflict, then four more
    iq.push_back(32'h0000_0020);
    dq.push_back(mk_job(1'b0, 32'h0000_0040, '0));
    run_until_idle(60, "conflict_done");
    check_eq("cnt_conflicts_one", LINE_W'(cnt_conflicts), LINE_W'(32'd1));
    for (int k = 0; k < 4; k++) begin
      iq.push_back(rand_addr());
      dq.push_back(mk_job(1'(k % 2), rand_addr(), rand_line()));
      run_until_idle(60, "conflict_rep_done");
    end
    check_eq("cnt_conflicts_five", LINE_W'(cnt_conflicts), LINE_W'(32'd5));

    // Reset two cycles into SERVE_D abandons the write
    mem_lat = 10;
    dq.push_back(mk_job(1'b1, 32'h0000_1000, PAT_B2));
    n = 0; sc = 0;
    while (sc < 2 && n < 40) begin
      step();
      if (owner == OWN_D) sc++;
      n++;
    end
    check_eq("serve_d_reached", LINE_W'(sc), LINE_W'(2));
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async_m_write", LINE_W'(bus.m_write), '0);
    check_eq("rst_async_m_read",  LINE_W'(bus.m_read),  '0);
    check_eq("rst_async_cnt_d",   LINE_W'(cnt_d_grants), '0);
    check_eq("rst_async_cnt_c",   LINE_W'(cnt_conflicts), '0);
    owner = OWN_NONE; last_side = OWN_I;
    m_cnt_i = '0; m_cnt_d = '0; m_cnt_c = '0;
    d_act = 0; d_done = 0; i_act = 0; i_done = 0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.i_read = 1'b0;
    mem_stale = mem_busy;
    repeat (2) step();
    rst_n = 1'b1;
    run_until_idle(40, "stale_resp_drain");

    // Randomized traffic with address flips and spurious responses
    mem_lat = 0; flip_en = 1; spur_en = 1;
    for (int c = 0; c < 3000; c++) begin
      if (iq.size() < 2 && $urandom_range(0, 3) == 0) iq.push_back(rand_addr());
      if (dq.size() < 2 && $urandom_range(0, 3) == 0)
        dq.push_back(mk_job(1'($urandom_range(0, 1)), rand_addr(), rand_line()));
      step();
    end
    spur_en = 0;
    run_until_idle(400, "final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
